// File: rtl/dff_pipe.sv
`timescale 1ns/1ps
// dff_pipe: DEPTH-stage, WIDTH-bit register pipeline with load enable and sync clear.
// Define DFF_PIPE_EDGE_DETECT_EN to add per-bit rise/fall flags on q.
module dff_pipe #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
`ifdef DFF_PIPE_EDGE_DETECT_EN
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`else
  output logic [WIDTH-1:0] q
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb begin
        stage_d = stage_q;
        if (clr) begin
          stage_d[0] = RESET_VAL;
        end else if (en) begin
          stage_d[0] = d;
        end
      end
    end else begin : g_chain
      // stage[0] takes d; every later stage takes its predecessor
      always_comb begin
        stage_d = stage_q;
        if (clr) begin
          stage_d = {DEPTH{RESET_VAL}};
        end else if (en) begin
          stage_d = {stage_q[DEPTH-2:0], d};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[DEPTH-1];

`ifdef DFF_PIPE_EDGE_DETECT_EN
  logic [WIDTH-1:0] q_dly_q;

  // Tracks q every cycle, independent of en, so flags last one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_dly_q <= RESET_VAL;
    end else begin
      q_dly_q <= stage_q[DEPTH-1];
    end
  end

  assign rise = q & ~q_dly_q;
  assign fall = ~q & q_dly_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
`timescale 1ns/1ps
// tb_dff_pipe: table vectors plus hand sequences for reset, sampling and edge flags.
// Two instances: DEPTH=1/WIDTH=4/RESET_VAL=0 and DEPTH=3/WIDTH=8/RESET_VAL=0xA5.
module tb_dff_pipe;

  localparam logic [7:0] RV3 = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [3:0] d1;
  logic [3:0] q1;
  logic [7:0] d3;
  logic [7:0] q3;
`ifdef DFF_PIPE_EDGE_DETECT_EN
  logic [3:0] rise1, fall1;
  logic [7:0] rise3, fall3;
`endif

  int nchecks = 0;
  int nerrors = 0;

  always #10 clk = ~clk;

  dff_pipe #(.WIDTH(4), .DEPTH(1), .RESET_VAL(4'h0)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d1),
`ifdef DFF_PIPE_EDGE_DETECT_EN
    .rise(rise1), .fall(fall1),
`endif
    .q(q1)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV3)) u_d3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .d(d3),
`ifdef DFF_PIPE_EDGE_DETECT_EN
    .rise(rise3), .fall(fall3),
`endif
    .q(q3)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nchecks++;
    if (a !== e) begin
      nerrors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // While reset is high both outputs must sit at their reset values
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      chk("rst_hold_q1", {28'b0, q1}, 32'h0);
      chk("rst_hold_q3", {24'b0, q3}, {24'b0, RV3});
    end
  end

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] d1;
    logic [7:0] d3;
    logic [3:0] e1;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] exp1_q[$];
  logic [7:0] exp3_q[$];
  logic [7:0] m[3];

  function automatic void add(input logic e, input logic c,
                              input logic [3:0] a, input logic [7:0] b,
                              input logic [3:0] x);
    vec_t v;
    v.en = e; v.clr = c; v.d1 = a; v.d3 = b; v.e1 = x;
    tbl.push_back(v);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m[i] = RV3;
  endfunction

  // Called at negedge: drive, predict, then compare just after posedge
  task automatic step(input logic e, input logic c, input logic [3:0] a,
                      input logic [7:0] b, input logic [3:0] x);
    logic [3:0] g1;
    logic [7:0] g3;
    en = e; clr = c; d1 = a; d3 = b;
    if (c) begin
      model_reset();
    end else if (e) begin
      m[2] = m[1]; m[1] = m[0]; m[0] = b;
    end
    exp1_q.push_back(x);
    exp3_q.push_back(m[2]);
    @(posedge clk);
    #1;
    g1 = exp1_q.pop_front();
    g3 = exp3_q.pop_front();
    chk("q1", {28'b0, q1}, {28'b0, g1});
    chk("q3", {24'b0, q3}, {24'b0, g3});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b1; clr = 1'b0; d1 = 4'hF; d3 = 8'hFF;
    model_reset();
    #1;
    chk("reset_q1", {28'b0, q1}, 32'h0);
    chk("reset_q3", {24'b0, q3}, {24'b0, RV3});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // pulse widths 1..4 on q1; 0x11/0x22/0x33 stream through q3
    add(1, 0, 4'h1, 8'h11, 4'h1);
    add(1, 0, 4'h0, 8'h22, 4'h0);
    add(1, 0, 4'h1, 8'h33, 4'h1);
    add(1, 0, 4'h1, 8'h44, 4'h1);
    add(1, 0, 4'h0, 8'h55, 4'h0);
    add(1, 0, 4'h1, 8'h66, 4'h1);
    add(1, 0, 4'h1, 8'h77, 4'h1);
    add(1, 0, 4'h1, 8'h88, 4'h1);
    add(1, 0, 4'h0, 8'h99, 4'h0);
    add(1, 0, 4'h1, 8'h12, 4'h1);
    add(1, 0, 4'h1, 8'h23, 4'h1);
    add(1, 0, 4'h1, 8'h34, 4'h1);
    add(1, 0, 4'h1, 8'h45, 4'h1);
    add(1, 0, 4'h0, 8'h56, 4'h0);
    // hold with en low and d toggling
    add(1, 0, 4'h5, 8'h67, 4'h5);
    add(0, 0, 4'hA, 8'h78, 4'h5);
    add(0, 0, 4'h3, 8'h89, 4'h5);
    add(0, 0, 4'hF, 8'h9A, 4'h5);
    // clr beats en; clr also works with en low
    add(1, 1, 4'hF, 8'hFF, 4'h0);
    add(1, 0, 4'hF, 8'hC3, 4'hF);
    add(1, 0, 4'h6, 8'hD4, 4'h6);
    add(0, 1, 4'h9, 8'hE5, 4'h0);
    add(1, 0, 4'h2, 8'hF6, 4'h2);

    foreach (tbl[i]) step(tbl[i].en, tbl[i].clr, tbl[i].d1, tbl[i].d3,
                          tbl[i].e1);

    // Reset mid-stream: in-flight data must never reappear
    step(1, 0, 4'h1, 8'h5A, 4'h1);
    step(1, 0, 4'h1, 8'h5A, 4'h1);
    @(posedge clk);
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_q1", {28'b0, q1}, 32'h0);
    chk("async_rst_q3", {24'b0, q3}, {24'b0, RV3});
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("rst_5cyc_q1", {28'b0, q1}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    step(1, 0, 4'h1, 8'h3C, 4'h1);
    step(1, 0, 4'h1, 8'h3C, 4'h1);
    step(1, 0, 4'h1, 8'h3C, 4'h1);
    step(1, 0, 4'h0, 8'h3C, 4'h0);

    // d changed at negedge, held 5 cycles
    d1 = 4'h1;
    #9;
    chk("neg_pre_edge", {28'b0, q1}, 32'h0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("neg_held", {28'b0, q1}, 32'h1);
    end
    @(negedge clk);
    d1 = 4'h0;
    @(posedge clk);
    #1;
    chk("neg_drop", {28'b0, q1}, 32'h0);

    // Glitch between edges is never sampled
    @(negedge clk);
    d1 = 4'h1;
    #8;
    d1 = 4'h0;
    chk("glitch_mid", {28'b0, q1}, 32'h0);
    @(posedge clk);
    #1;
    chk("glitch_edge", {28'b0, q1}, 32'h0);
    @(posedge clk);
    #1;
    chk("glitch_next", {28'b0, q1}, 32'h0);

`ifdef DFF_PIPE_EDGE_DETECT_EN
    @(negedge clk);
    d1 = 4'h1;
    @(posedge clk);
    #1;
    chk("rise_on", {28'b0, rise1}, 32'h1);
    chk("fall_off", {28'b0, fall1}, 32'h0);
    @(posedge clk);
    #1;
    chk("rise_one_cyc", {28'b0, rise1}, 32'h0);
    @(negedge clk);
    d1 = 4'h0;
    @(posedge clk);
    #1;
    chk("fall_on", {28'b0, fall1}, 32'h1);
    chk("rise_quiet", {28'b0, rise1}, 32'h0);
    @(posedge clk);
    #1;
    chk("fall_one_cyc", {28'b0, fall1}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
